// File: rtl/bus_irq_ctrl_pkg.sv
// rtl/bus_irq_ctrl_pkg.sv - register offsets and mode encoding shared by bus_irq_ctrl
package bus_irq_ctrl_pkg;
  localparam logic [2:0] REG_RAW     = 3'd0;
  localparam logic [2:0] REG_STATUS  = 3'd1;
  localparam logic [2:0] REG_ENABLE  = 3'd2;
  localparam logic [2:0] REG_MODE    = 3'd3;
  localparam logic [2:0] REG_REARM   = 3'd4;
  localparam logic [2:0] REG_HOLDOFF = 3'd5;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_EDGE  = 1'b1;

  localparam int HOLDOFF_CNT_W = 16;
endpackage

// File: rtl/bus_irq_ctrl_sync.sv
// rtl/bus_irq_ctrl_sync.sv - multi-stage synchroniser for async interrupt inputs
module bus_irq_ctrl_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int k = 1; k < STAGES; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  assign q_o = stage_q[STAGES-1];
endmodule

// File: rtl/bus_irq_ctrl.sv
// rtl/bus_irq_ctrl.sv - interrupt controller register block (optional holdoff: BUS_IRQ_CTRL_HOLDOFF_EN)
module bus_irq_ctrl
  import bus_irq_ctrl_pkg::*;
#(
  parameter int ADDR           = 0,
  parameter int OFFSET         = 0,
  parameter int DATAWIDTH      = 8,
  parameter int BUS_ADDR_WIDTH = 24,
  parameter int BUS_DATA_WIDTH = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int HOLDOFF        = 16
) (
  input  logic                      bus_clk,
  input  logic                      bus_reset,
  input  logic                      bus_req,
  input  logic                      bus_rd_wr_l,
  input  logic [BUS_ADDR_WIDTH-1:0] bus_addr,
  input  logic [BUS_DATA_WIDTH-1:0] bus_wr_data,
  output logic                      bus_rtn,
  output logic [BUS_DATA_WIDTH-1:0] bus_rd_data,
  input  logic [DATAWIDTH-1:0]      in,
  output logic [DATAWIDTH-1:0]      raw,
  output logic [DATAWIDTH-1:0]      irq_rearm,
  output logic                      irq
);
`ifdef BUS_IRQ_CTRL_HOLDOFF_EN
  localparam int NUM_REGS = 6;
`else
  localparam int NUM_REGS = 5;
`endif
  localparam logic [BUS_ADDR_WIDTH-1:0] BASE  = BUS_ADDR_WIDTH'(ADDR);
  localparam logic [BUS_ADDR_WIDTH-1:0] LIMIT = BUS_ADDR_WIDTH'(NUM_REGS);

  logic [DATAWIDTH-1:0]      raw_s, prev_q, status_q, status_d;
  logic [DATAWIDTH-1:0]      enable_q, mode_q, mode_d, rearm_q;
  logic [DATAWIDTH-1:0]      wdata, w1c, mode_flip;
  logic [BUS_ADDR_WIDTH-1:0] off;
  logic [2:0]                sel;
  logic                      hit, wr, rd, mode_wr, agg;
  logic                      rtn_q, irq_q, irq_d;
  logic [BUS_DATA_WIDTH-1:0] rd_data_q, rd_word;

  bus_irq_ctrl_sync #(
    .WIDTH (DATAWIDTH),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i(bus_clk),
    .rst_i(bus_reset),
    .d_i  (in),
    .q_o  (raw_s)
  );

  assign off       = bus_addr - BASE;
  assign hit       = (bus_addr >= BASE) && (off < LIMIT);
  assign sel       = off[2:0];
  assign wr        = bus_req && hit && !bus_rd_wr_l;
  assign rd        = bus_req && hit && bus_rd_wr_l;
  assign wdata     = bus_wr_data[OFFSET +: DATAWIDTH];
  assign w1c       = (wr && sel == REG_STATUS) ? wdata : '0;
  assign mode_wr   = wr && sel == REG_MODE;
  assign mode_d    = mode_wr ? wdata : mode_q;
  assign mode_flip = mode_d ^ mode_q;
  assign agg       = |(status_q & enable_q);

  // A channel whose mode flips starts from a clean status; a new edge beats W1C.
  always_comb begin
    status_d = status_q;
    for (int i = 0; i < DATAWIDTH; i++) begin
      if (mode_flip[i])
        status_d[i] = 1'b0;
      else if (mode_q[i] == MODE_LEVEL)
        status_d[i] = raw_s[i];
      else
        status_d[i] = (status_q[i] & ~w1c[i]) | (raw_s[i] & ~prev_q[i]);
    end
  end

`ifdef BUS_IRQ_CTRL_HOLDOFF_EN
  logic [HOLDOFF_CNT_W-1:0] hold_q, hold_d;

  always_comb begin
    hold_d = hold_q;
    if (|(w1c & status_q & mode_q))
      hold_d = HOLDOFF_CNT_W'(HOLDOFF);
    else if (hold_q != '0)
      hold_d = hold_q - 1'b1;
  end

  always_ff @(posedge bus_clk) begin
    if (bus_reset) hold_q <= '0;
    else           hold_q <= hold_d;
  end

  assign irq_d = agg && (hold_q == '0);
`else
  assign irq_d = agg;
`endif

  always_comb begin
    rd_word = '0;
    case (sel)
      REG_RAW:    rd_word[OFFSET +: DATAWIDTH] = raw_s;
      REG_STATUS: rd_word[OFFSET +: DATAWIDTH] = status_q;
      REG_ENABLE: rd_word[OFFSET +: DATAWIDTH] = enable_q;
      REG_MODE:   rd_word[OFFSET +: DATAWIDTH] = mode_q;
      REG_REARM:  rd_word[OFFSET +: DATAWIDTH] = rearm_q;
`ifdef BUS_IRQ_CTRL_HOLDOFF_EN
      // The count sits at the bottom of the word regardless of OFFSET.
      REG_HOLDOFF: rd_word[HOLDOFF_CNT_W-1:0] = hold_q;
`endif
      default:    rd_word = '0;
    endcase
  end

  always_ff @(posedge bus_clk) begin
    if (bus_reset) begin
      rtn_q     <= 1'b0;
      rd_data_q <= '0;
      prev_q    <= '0;
      status_q  <= '0;
      enable_q  <= '0;
      mode_q    <= '0;
      rearm_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      rtn_q     <= bus_req && hit;
      rd_data_q <= rd ? rd_word : '0;
      prev_q    <= raw_s;
      status_q  <= status_d;
      mode_q    <= mode_d;
      irq_q     <= irq_d;
      if (wr && sel == REG_ENABLE) enable_q <= wdata;
      if (wr && sel == REG_REARM)  rearm_q  <= rearm_q ^ wdata;
    end
  end

  assign bus_rtn     = rtn_q;
  assign bus_rd_data = rd_data_q;
  assign raw         = raw_s;
  assign irq_rearm   = rearm_q;
  assign irq         = irq_q;
endmodule

// File: tb/tb_bus_irq_ctrl.sv
// tb/tb_bus_irq_ctrl.sv - self-checking bench for bus_irq_ctrl against a cycle-level behavioural model
module tb_bus_irq_ctrl;
  localparam int ADDR = 8;
  localparam int S    = 2;
  localparam int HO   = 16;
`ifdef BUS_IRQ_CTRL_HOLDOFF_EN
  localparam int NREG = 6;
`else
  localparam int NREG = 5;
`endif

  logic        bus_clk = 0;
  logic        bus_reset, bus_req, bus_rd_wr_l, bus_rtn, irq;
  logic [23:0] bus_addr;
  logic [31:0] bus_wr_data, bus_rd_data;
  logic [7:0]  in, raw, irq_rearm;

  int tests = 0;
  int fails = 0;

  bus_irq_ctrl #(
    .ADDR(ADDR), .OFFSET(0), .DATAWIDTH(8), .BUS_ADDR_WIDTH(24),
    .BUS_DATA_WIDTH(32), .SYNC_STAGES(S), .HOLDOFF(HO)
  ) dut (
    .bus_clk(bus_clk), .bus_reset(bus_reset), .bus_req(bus_req),
    .bus_rd_wr_l(bus_rd_wr_l), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
    .bus_rtn(bus_rtn), .bus_rd_data(bus_rd_data), .in(in), .raw(raw),
    .irq_rearm(irq_rearm), .irq(irq)
  );

  always #5 bus_clk = ~bus_clk;

  // Reference model: in_h[k] is the input as seen k+1 edges ago.
  bit [7:0]  in_h [S+1];
  bit [7:0]  m_raw, m_st, m_en, m_mode, m_rearm;
  bit        m_irq, m_rtn;
  bit [31:0] m_rd;
  int        m_cnt;

  always @(posedge bus_clk) begin : model
    bit [7:0] cur, prev, w1c, nmode, nst;
    int o;
    bit h, nirq;
    if (bus_reset) begin
      for (int k = 0; k <= S; k++) in_h[k] = 0;
      m_raw = 0; m_st = 0; m_en = 0; m_mode = 0; m_rearm = 0;
      m_irq = 0; m_rtn = 0; m_rd = 0; m_cnt = 0;
    end else begin
      cur   = in_h[S-1];
      prev  = in_h[S];
      o     = int'(bus_addr) - ADDR;
      h     = bus_req && o >= 0 && o < NREG;
      w1c   = 0;
      nmode = m_mode;
      m_rtn = h;
      m_rd  = 0;
      if (h && bus_rd_wr_l) begin
        case (o)
          0: m_rd = {24'd0, m_raw};
          1: m_rd = {24'd0, m_st};
          2: m_rd = {24'd0, m_en};
          3: m_rd = {24'd0, m_mode};
          4: m_rd = {24'd0, m_rearm};
          default: m_rd = 32'(m_cnt);
        endcase
      end
      nirq = ((m_st & m_en) != 0) && (m_cnt == 0);
      if (h && !bus_rd_wr_l) begin
        case (o)
          1: w1c = bus_wr_data[7:0];
          2: m_en = bus_wr_data[7:0];
          3: nmode = bus_wr_data[7:0];
          4: m_rearm = m_rearm ^ bus_wr_data[7:0];
          default: ;
        endcase
      end
      for (int i = 0; i < 8; i++) begin
        if (nmode[i] != m_mode[i]) nst[i] = 0;
        else if (m_mode[i])        nst[i] = (m_st[i] && !w1c[i]) || (cur[i] && !prev[i]);
        else                       nst[i] = cur[i];
      end
`ifdef BUS_IRQ_CTRL_HOLDOFF_EN
      if ((w1c & m_st & m_mode) != 0) m_cnt = HO;
      else if (m_cnt > 0)             m_cnt = m_cnt - 1;
`endif
      m_st   = nst;
      m_mode = nmode;
      m_irq  = nirq;
      for (int k = S; k > 0; k--) in_h[k] = in_h[k-1];
      in_h[0] = in;
      m_raw   = in_h[S-1];
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge bus_clk);
  endtask

  task automatic do_bus(input bit rd, input int o, input logic [31:0] d,
                        output logic rtn, output logic [31:0] rdat);
    bus_req = 1; bus_rd_wr_l = rd; bus_addr = 24'(ADDR + o); bus_wr_data = d;
    @(negedge bus_clk);
    bus_req = 0;
    rtn  = bus_rtn;
    rdat = bus_rd_data;
  endtask

  task automatic test_reset;
    logic r; logic [31:0] d;
    bus_reset = 1; bus_req = 0; bus_rd_wr_l = 1; bus_addr = 0; bus_wr_data = 0; in = 0;
    tick(3);
    tests++; if ({bus_rtn, bus_rd_data, irq_rearm, irq} !== 42'd0) begin
      fails++; $display("FAIL reset_outputs: got rtn=%b rd=%h rearm=%h irq=%b want all 0",
                        bus_rtn, bus_rd_data, irq_rearm, irq); end
    bus_reset = 0;
    tick(1);
    for (int o = 0; o < 5; o++) begin
      do_bus(1, o, 0, r, d);
      tests++; if (r !== 1'b1 || d !== 32'd0) begin
        fails++; $display("FAIL reset_read_%0d: got rtn=%b rd=%h want rtn=1 rd=0", o, r, d); end
    end
    tests++; if (irq !== 1'b0) begin
      fails++; $display("FAIL reset_irq: got %b want 0", irq); end
  endtask

  task automatic test_reset_mid;
    logic r; logic [31:0] d;
    do_bus(0, 4, 32'h3, r, d);
    bus_req = 1; bus_rd_wr_l = 1; bus_addr = 24'(ADDR + 2); bus_reset = 1;
    @(negedge bus_clk);
    bus_req = 0;
    tests++; if (bus_rtn !== 1'b0 || irq_rearm !== 8'h00 || bus_rd_data !== 32'd0) begin
      fails++; $display("FAIL reset_mid: got rtn=%b rearm=%h rd=%h want 0 0 0",
                        bus_rtn, irq_rearm, bus_rd_data); end
    bus_reset = 0;
    tick(1);
  endtask

  task automatic test_edge;
    logic r; logic [31:0] d;
    do_bus(0, 3, 32'h01, r, d);
    do_bus(0, 2, 32'h01, r, d);
    in = 8'h01; @(negedge bus_clk); in = 8'h00;
    tick(S);
    tests++; if (irq !== 1'b0) begin
      fails++; $display("FAIL edge_irq_early: got %b want 0", irq); end
    do_bus(1, 1, 0, r, d);
    tests++; if (d !== 32'h01 || d !== m_rd) begin
      fails++; $display("FAIL edge_status: got %h want 01 (model %h)", d, m_rd); end
    tests++; if (irq !== 1'b1) begin
      fails++; $display("FAIL edge_irq: got %b want 1", irq); end
    do_bus(0, 1, 32'h01, r, d);
    tick(1);
    tests++; if (irq !== 1'b0) begin
      fails++; $display("FAIL edge_w1c_irq: got %b want 0", irq); end
    do_bus(1, 1, 0, r, d);
    tests++; if (d !== 32'h00) begin
      fails++; $display("FAIL edge_w1c_status: got %h want 00", d); end
  endtask

  task automatic test_w1c_race;
    logic r; logic [31:0] d;
    do_bus(0, 3, 32'h05, r, d);
    in = 8'h04; @(negedge bus_clk); in = 8'h00;
    tick(S - 1);
    do_bus(0, 1, 32'h04, r, d);
    do_bus(1, 1, 0, r, d);
    tests++; if (d !== 32'h04 || d !== m_rd) begin
      fails++; $display("FAIL w1c_race: got %h want 04 (model %h)", d, m_rd); end
    do_bus(0, 1, 32'h04, r, d);
    do_bus(1, 1, 0, r, d);
    tests++; if (d !== 32'h00) begin
      fails++; $display("FAIL w1c_race_clear: got %h want 00", d); end
  endtask

  task automatic test_level;
    logic r; logic [31:0] d;
    do_bus(0, 2, 32'h08, r, d);
    in = 8'h08;
    tick(S + 3);
    tests++; if (irq !== 1'b1) begin
      fails++; $display("FAIL level_irq: got %b want 1", irq); end
    do_bus(0, 1, 32'h08, r, d);
    do_bus(1, 1, 0, r, d);
    tests++; if ((d & 32'h08) !== 32'h08 || d !== m_rd) begin
      fails++; $display("FAIL level_w1c: got %h want bit3 set (model %h)", d, m_rd); end
    in = 8'h00;
    tick(S + 1);
    tests++; if (irq !== 1'b1) begin
      fails++; $display("FAIL level_drop_early: got %b want 1", irq); end
    tick(1);
    tests++; if (irq !== 1'b0) begin
      fails++; $display("FAIL level_drop: got %b want 0", irq); end
  endtask

  task automatic test_rearm_unmapped;
    logic r; logic [31:0] d;
    do_bus(0, 4, 32'h05, r, d);
    tests++; if (irq_rearm !== 8'h05) begin
      fails++; $display("FAIL rearm_1: got %h want 05", irq_rearm); end
    do_bus(1, 4, 0, r, d);
    tests++; if (d !== 32'h05) begin
      fails++; $display("FAIL rearm_rd_1: got %h want 05", d); end
    do_bus(0, 4, 32'h04, r, d);
    tests++; if (irq_rearm !== 8'h01) begin
      fails++; $display("FAIL rearm_2: got %h want 01", irq_rearm); end
    do_bus(1, 4, 0, r, d);
    tests++; if (d !== 32'h01) begin
      fails++; $display("FAIL rearm_rd_2: got %h want 01", d); end
    do_bus(1, -1, 0, r, d);
    tests++; if (r !== 1'b0 || d !== 32'd0) begin
      fails++; $display("FAIL unmapped_below: got rtn=%b rd=%h want 0 0", r, d); end
    do_bus(1, 6, 0, r, d);
    tests++; if (r !== 1'b0 || d !== 32'd0) begin
      fails++; $display("FAIL unmapped_above: got rtn=%b rd=%h want 0 0", r, d); end
`ifndef BUS_IRQ_CTRL_HOLDOFF_EN
    do_bus(1, 5, 0, r, d);
    tests++; if (r !== 1'b0 || d !== 32'd0) begin
      fails++; $display("FAIL unmapped_holdoff: got rtn=%b rd=%h want 0 0", r, d); end
`endif
  endtask

`ifdef BUS_IRQ_CTRL_HOLDOFF_EN
  task automatic test_holdoff;
    logic r; logic [31:0] d;
    do_bus(0, 3, 32'h02, r, d);
    do_bus(0, 2, 32'h02, r, d);
    in = 8'h02; tick(S + 3);
    tests++; if (irq !== 1'b1) begin
      fails++; $display("FAIL holdoff_pre: got %b want 1", irq); end
    do_bus(0, 1, 32'h02, r, d);
    for (int c = 0; c < HO; c++) begin
      in = (c % 4 < 2) ? 8'h00 : 8'h02;
      if (c == 3) begin
        do_bus(1, 5, 0, r, d);
        tests++; if (d !== 32'(HO - 3) || d !== m_rd) begin
          fails++; $display("FAIL holdoff_cnt: got %0d want %0d", d, HO - 3); end
      end else tick(1);
      tests++; if (irq !== 1'b0) begin
        fails++; $display("FAIL holdoff_gate_%0d: got %b want 0", c, irq); end
    end
    tick(1);
    tests++; if (irq !== 1'b1 || irq !== m_irq) begin
      fails++; $display("FAIL holdoff_release: got %b want 1", irq); end
    in = 8'h00;
  endtask
`endif

  task automatic test_random;
    for (int c = 0; c < 400; c++) begin
      in          = 8'($urandom);
      bus_req     = ($urandom_range(0, 2) != 0);
      bus_rd_wr_l = $urandom_range(0, 1) == 1;
      bus_addr    = 24'(ADDR - 1 + int'($urandom_range(0, 7)));
      bus_wr_data = $urandom;
      @(negedge bus_clk);
      tests++; if (bus_rtn !== m_rtn) begin
        fails++; $display("FAIL rnd_rtn[%0d]: got %b want %b", c, bus_rtn, m_rtn); end
      tests++; if (bus_rd_data !== m_rd) begin
        fails++; $display("FAIL rnd_rd[%0d]: got %h want %h", c, bus_rd_data, m_rd); end
      tests++; if (raw !== m_raw) begin
        fails++; $display("FAIL rnd_raw[%0d]: got %h want %h", c, raw, m_raw); end
      tests++; if (irq_rearm !== m_rearm) begin
        fails++; $display("FAIL rnd_rearm[%0d]: got %h want %h", c, irq_rearm, m_rearm); end
      tests++; if (irq !== m_irq) begin
        fails++; $display("FAIL rnd_irq[%0d]: got %b want %b", c, irq, m_irq); end
    end
    bus_req = 0;
    tick(1);
  endtask

  initial begin
    test_reset;
    test_reset_mid;
    test_edge;
    test_w1c_race;
    test_level;
    test_rearm_unmapped;
`ifdef BUS_IRQ_CTRL_HOLDOFF_EN
    test_holdoff;
`endif
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
